// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : period_meter_pkg
// Description : Shared types and default constants for the period meter.
// Revision    : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

    // Measurement FSM: waiting for the first edge, or timing full intervals
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int          DEF_CNT_W       = 32;
    localparam int unsigned DEF_TIMEOUT     = 100_000_000;
    localparam int          DEF_SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/period_meter_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Multi-flop synchronizer for an asynchronous level, followed
//               by one delay flop for rising/falling edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // One-cycle delayed copy of the synchronized level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= s;
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = s & ~r_s_d;
    assign fall = ~s & r_s_d;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Measures period and high time of a slow asynchronous square
//               wave in clk_in cycles, with loss-of-signal timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module period_meter
    import period_meter_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_hlat;
    logic             w_cnt_at_limit;
    logic             w_timeout_hit;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk_in),
        .rst_n (reset_n),
        .din   (sig_in),
        .s     (w_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // A rise in the limit cycle is a legal interval of exactly TIMEOUT
    assign w_cnt_at_limit = (r_cnt == c_timeout);
    assign w_timeout_hit  = w_cnt_at_limit & ~w_rise;

    // State register
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: clear dominates, then rise, then timeout
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_rise)        w_next_state = MEASURE;
                MEASURE: if (w_timeout_hit) w_next_state = IDLE;
                default:                    w_next_state = IDLE;
            endcase
        end
    end

    // Output decode: locked simply reflects the measuring state
    always_comb begin
        locked = (r_state == MEASURE);
    end

    // Counters, high-time latch and result registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_hlat    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else if (clear) begin
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_hlat    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_rise) begin
                // The rising edge cycle itself is the first counted cycle
                r_cnt   <= c_one;
                r_hcnt  <= c_one;
                timeout <= 1'b0;
                if (r_state == MEASURE) begin
                    period    <= r_cnt;
                    high_time <= r_hlat;
                    valid     <= 1'b1;
                end
            end else if (w_cnt_at_limit) begin
                timeout <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
                if (r_state == MEASURE) begin
                    if (w_s) begin
                        r_hcnt <= r_hcnt + c_one;
                    end
                    if (w_fall) begin
                        r_hlat <= r_hcnt;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_period_meter
// Description : Self-checking bench for period_meter (SYNC_STAGES=2,
//               TIMEOUT=1000) with a level-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int CNT_W = 32;
    localparam int TMO   = 1000;

    logic             clk_in  = 1'b0;
    logic             reset_n = 1'b1;
    logic             sig_in  = 1'b0;
    logic             clear   = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             locked;

    int total = 0;
    int bad   = 0;

    // Stimulus stream (one level per cycle) and model expectations
    bit               stream[$];
    int               exp_p[$];
    int               exp_h[$];
    // Observed results, recorded by the monitor
    logic [CNT_W-1:0] obs_p[$];
    logic [CNT_W-1:0] obs_h[$];
    int               obs_c[$];
    int               cyc = 0;
    int               to_rise_cyc = -1;
    int               to_fall_cyc = -1;
    int               lock_fall_cyc = -1;
    int               to_rises = 0;
    bit               prev_to = 1'b0;
    bit               prev_lock = 1'b0;

    period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TMO),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .clear     (clear),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clk_in = ~clk_in;

    // Monitor: samples outputs 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            cyc = cyc + 1;
            if (valid === 1'b1) begin
                obs_p.push_back(period);
                obs_h.push_back(high_time);
                obs_c.push_back(cyc);
            end
            if (timeout === 1'b1 && !prev_to) begin
                to_rise_cyc = cyc;
                to_rises    = to_rises + 1;
            end
            if (timeout === 1'b0 && prev_to) to_fall_cyc = cyc;
            if (locked === 1'b0 && prev_lock) lock_fall_cyc = cyc;
            prev_to   = (timeout === 1'b1);
            prev_lock = (locked === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, limit reached", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic flush_obs();
        obs_p.delete(); obs_h.delete(); obs_c.delete();
        to_rises = 0; to_rise_cyc = -1; to_fall_cyc = -1; lock_fall_cyc = -1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush_obs();
    endtask

    task automatic add_wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (h) stream.push_back(1'b1);
            repeat (p - h) stream.push_back(1'b0);
        end
    endtask

    task automatic add_gap(input int n);
        repeat (n) stream.push_back(1'b0);
    endtask

    task automatic play_range(input int from, input int to);
        for (int k = from; k < to; k++) begin
            sig_in = stream[k];
            tick();
        end
    endtask

    // Reference: results are rise-to-rise distances in the level stream; an
    // interval longer than TMO disarms, and the next rise only re-arms.
    function automatic void build_model();
        bit armed = 1'b0;
        bit prev  = 1'b0;
        int last  = 0;
        int hi;
        exp_p.delete(); exp_h.delete();
        for (int k = 0; k < stream.size(); k++) begin
            if (armed && (k - last) > TMO) armed = 1'b0;
            if (stream[k] && !prev) begin
                if (armed) begin
                    hi = 0;
                    for (int j = last; j < k && stream[j]; j++) hi++;
                    exp_p.push_back(k - last);
                    exp_h.push_back(hi);
                end
                armed = 1'b1;
                last  = k;
            end
            prev = stream[k];
        end
    endfunction

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) tick();
        total++; if (period !== 0)    begin bad++; $display("FAIL rst_period: got %0d want 0", period); end
        total++; if (high_time !== 0) begin bad++; $display("FAIL rst_high: got %0d want 0", high_time); end
        total++; if (valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
        reset_n = 1'b1;
        tick();
        stream.delete(); add_wave(40, 15, 3);
        play_range(0, stream.size());
        sig_in = 1'b1;
        repeat (5) tick();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL pre_reset_locked: got %b want 1", locked); end
        @(posedge clk_in); #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({period, high_time, valid, timeout, locked} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got p=%0d h=%0d v=%b t=%b l=%b want all 0",
                     period, high_time, valid, timeout, locked);
        end
        tick(); sig_in = 1'b0; tick(); reset_n = 1'b1; tick();
        flush_obs();
        stream.delete(); add_wave(100, 30, 3); add_gap(8);
        build_model();
        play_range(0, stream.size());
        total++;
        if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL reset_wave_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total++;
            if (obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
                bad++; $display("FAIL reset_wave[%0d]: got %0d/%0d want %0d/%0d", i, obs_p[i], obs_h[i], exp_p[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_min_period();
        do_clear();
        stream.delete(); add_wave(2, 1, 20); add_gap(8);
        build_model();
        play_range(0, stream.size());
        total++;
        if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL min_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total++;
            if (obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
                bad++; $display("FAIL min_result[%0d]: got %0d/%0d want %0d/%0d", i, obs_p[i], obs_h[i], exp_p[i], exp_h[i]);
            end
            if (i > 0) begin
                total++;
                if (obs_c[i] - obs_c[i-1] !== 2) begin
                    bad++; $display("FAIL min_spacing[%0d]: got %0d want 2", i, obs_c[i] - obs_c[i-1]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int split;
        int last_v;
        do_clear();
        stream.delete(); add_wave(50, 20, 3); add_gap(1100);
        split = stream.size();
        add_wave(60, 25, 2); add_gap(8);
        build_model();
        play_range(0, split);
        last_v = (obs_c.size() > 0) ? obs_c[obs_c.size()-1] : -100000;
        total++; if (to_rise_cyc - last_v !== TMO) begin bad++; $display("FAIL to_delay: got %0d want %0d", to_rise_cyc - last_v, TMO); end
        total++; if (lock_fall_cyc !== to_rise_cyc) begin bad++; $display("FAIL to_lock_fall: got %0d want %0d", lock_fall_cyc, to_rise_cyc); end
        total++;
        if (timeout !== 1'b1 || locked !== 1'b0 || period !== 50 || high_time !== 20) begin
            bad++; $display("FAIL to_hold: got t=%b l=%b p=%0d h=%0d want t=1 l=0 p=50 h=20", timeout, locked, period, high_time);
        end
        play_range(split, stream.size());
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_cleared: got %b want 0", timeout); end
        total++;
        if (obs_c.size() < 3 || to_fall_cyc !== obs_c[2] - 60) begin
            bad++; $display("FAIL to_clear_time: got %0d want one period before valid at %0d", to_fall_cyc, (obs_c.size() < 3) ? -1 : obs_c[2]);
        end
        total++;
        if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL to_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total++;
            if (obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
                bad++; $display("FAIL to_result[%0d]: got %0d/%0d want %0d/%0d", i, obs_p[i], obs_h[i], exp_p[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_boundary();
        do_clear();
        stream.delete(); add_wave(TMO, 10, 2); add_wave(20, 10, 1); add_gap(8);
        build_model();
        play_range(0, stream.size());
        total++; if (to_rises !== 0) begin bad++; $display("FAIL edge_gap_timeout: got %0d timeout events want 0", to_rises); end
        total++;
        if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL edge_gap_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total++;
            if (obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
                bad++; $display("FAIL edge_gap[%0d]: got %0d/%0d want %0d/%0d", i, obs_p[i], obs_h[i], exp_p[i], exp_h[i]);
            end
        end
        do_clear();
        stream.delete(); add_wave(TMO + 1, 10, 1); add_wave(20, 10, 1); add_gap(8);
        build_model();
        play_range(0, stream.size());
        total++; if (to_rises !== 1) begin bad++; $display("FAIL over_gap_timeout: got %0d timeout events want 1", to_rises); end
        total++; if (to_fall_cyc - to_rise_cyc !== 1) begin bad++; $display("FAIL over_gap_pulse: got %0d cycles want 1", to_fall_cyc - to_rise_cyc); end
        total++; if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL over_gap_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL over_gap_rearm: got %b want 1", locked); end
    endtask

    task automatic test_clear_rise();
        do_clear();
        stream.delete(); add_wave(50, 20, 3);
        play_range(0, stream.size());
        sig_in = 1'b1;
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if ({period, high_time, valid, timeout, locked} !== '0) begin
            bad++; $display("FAIL clr_rise_outputs: got p=%0d h=%0d v=%b t=%b l=%b want all 0", period, high_time, valid, timeout, locked);
        end
        tick();
        total++; if (valid !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL clr_rise_after: got v=%b l=%b want 0 0", valid, locked); end
        repeat (10) tick();
        sig_in = 1'b0;
        repeat (10) tick();
        flush_obs();
        stream.delete(); add_wave(60, 25, 2); add_gap(8);
        build_model();
        play_range(0, stream.size());
        total++;
        if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL clr_next_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total++;
            if (obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
                bad++; $display("FAIL clr_next[%0d]: got %0d/%0d want %0d/%0d", i, obs_p[i], obs_h[i], exp_p[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_random_waves();
        int p, h;
        do_clear();
        stream.delete();
        for (int seg = 0; seg < 6; seg++) begin
            p = $urandom_range(2, 300);
            h = $urandom_range(1, p - 1);
            add_wave(p, h, $urandom_range(2, 5));
            if ($urandom_range(0, 3) == 0) add_gap($urandom_range(1, 1100));
        end
        add_wave(7, 3, 1); add_gap(8);
        build_model();
        play_range(0, stream.size());
        total++;
        if (obs_p.size() !== exp_p.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", obs_p.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total++;
            if (obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
                bad++; $display("FAIL rnd_result[%0d]: got %0d/%0d want %0d/%0d", i, obs_p[i], obs_h[i], exp_p[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_async();
        int t;
        int e;
        int dp, dh;
        do_clear();
        stream.delete(); add_wave(10, 5, 1);
        play_range(0, stream.size());
        sig_in = 1'b1;
        tick(); tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_early: got %b want 0", valid); end
        tick();
        total++;
        if (valid !== 1'b1 || period !== 10 || high_time !== 5) begin
            bad++; $display("FAIL latency_3: got v=%b p=%0d h=%0d want v=1 p=10 h=5", valid, period, high_time);
        end
        repeat (5) tick();
        sig_in = 1'b0;
        repeat (8) tick();
        do_clear();
        @(posedge clk_in);
        t = 0;
        for (int n = 0; n < 6; n++) begin
            e = n * 2500 + $urandom_range(1, 9);
            #(e - t); t = e; sig_in = 1'b1;
            e = n * 2500 + 1250 + $urandom_range(1, 9);
            #(e - t); t = e; sig_in = 1'b0;
        end
        repeat (8) tick();
        total++; if (obs_p.size() !== 5) begin bad++; $display("FAIL async_count: got %0d want 5", obs_p.size()); end
        for (int i = 0; i < obs_p.size(); i++) begin
            dp = int'(obs_p[i]) - 250;
            dh = int'(obs_h[i]) - 125;
            total++;
            if (dp < -1 || dp > 1 || dh < -1 || dh > 1) begin
                bad++; $display("FAIL async_result[%0d]: got %0d/%0d want 250/125 +-1", i, obs_p[i], obs_h[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_min_period();
        test_timeout();
        test_boundary();
        test_clear_rise();
        test_random_waves();
        test_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
